pipe_add_sub: RTL and testbench



---
 rtl/pipe_arith_pkg.sv | 16 +
 rtl/add_seg.sv | 22 ++
 rtl/pipe_add_sub.sv | 107 ++++++++++
 tb/tb_pipe_add_sub.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the pipelined add/sub datapath: op encoding and
// segment-width helper.
package pipe_arith_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_INC  = 2'b10;
  localparam op_t OP_ADDC = 2'b11;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_seg.sv
// One carry-chain segment: SEG-bit add with carry in/out plus the carry that
// enters the segment MSB (needed for signed overflow on the top segment).
module add_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic [SEG:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  assign o_sum  = w_full[SEG-1:0];
  assign o_cout = w_full[SEG];
  // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
  assign o_cmsb = i_a[SEG-1] ^ i_b[SEG-1] ^ w_full[SEG-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit ADD/SUB/INC/ADDC. Carry chain split into STAGES segments,
// one per register stage; whole pipe stalls on output backpressure.
module pipe_add_sub
  import pipe_arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

  logic                          w_en;
  logic [WIDTH-1:0]              w_bc;
  logic                          w_cc;
  logic [STAGES:0]               w_vld_pipe;
  logic [STAGES:1]               r_vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]  r_a, r_b, r_s;
  logic [STAGES-1:0][WIDTH-1:0]  w_ain, w_bin, w_sin, w_snext;
  logic [STAGES-1:0][SEG-1:0]    w_seg;
  logic [STAGES-1:0]             r_c, w_cin, w_co, w_cm;
  logic                          r_cm;
  logic                          w_unused;

  assign w_en       = ~r_vld_pipe[STAGES] | out_ready;
  assign in_ready   = w_en;
  assign w_vld_pipe = {r_vld_pipe, in_valid};

  always_comb begin
    w_bc = b;
    w_cc = 1'b0;
    case (op)
      OP_SUB:  begin w_bc = ~b;  w_cc = 1'b1; end
      OP_INC:  begin w_bc = '0;  w_cc = 1'b1; end
      OP_ADDC: w_cc = ci;
      default: ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_ain[k] = a;
      assign w_bin[k] = w_bc;
      assign w_sin[k] = '0;
      assign w_cin[k] = w_cc;
    end else begin : g_next
      assign w_ain[k] = r_a[k-1];
      assign w_bin[k] = r_b[k-1];
      assign w_sin[k] = r_s[k-1];
      assign w_cin[k] = r_c[k-1];
    end

    add_seg #(.SEG(SEG)) u_seg (
      .i_a    (w_ain[k][k*SEG +: SEG]),
      .i_b    (w_bin[k][k*SEG +: SEG]),
      .i_cin  (w_cin[k]),
      .o_sum  (w_seg[k]),
      .o_cout (w_co[k]),
      .o_cmsb (w_cm[k])
    );

    // splice this stage's segment into the partial sum travelling down the pipe
    assign w_snext[k] = (w_sin[k] & ~(SEG_MASK << (k*SEG))) |
                        (WIDTH'(w_seg[k]) << (k*SEG));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_c        <= '0;
      r_cm       <= 1'b0;
    end else if (w_en) begin
      r_vld_pipe <= w_vld_pipe[STAGES-1:0];
      r_a        <= w_ain;
      r_b        <= w_bin;
      r_s        <= w_snext;
      r_c        <= w_co;
      r_cm       <= w_cm[STAGES-1];
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign sum       = out_valid ? r_s[STAGES-1] : '0;
  assign co        = out_valid & r_c[STAGES-1];
  assign ovf       = out_valid & (r_cm ^ r_c[STAGES-1]);

  // finished/unprocessed operand bits ride along but are never read again
  assign w_unused = ^{r_a, r_b, w_cm};

endmodule

// File: tb/tb_pipe_add_sub.sv
// Randomized + directed bench for pipe_add_sub (WIDTH=8, STAGES=2) against an
// arithmetic reference model and an in-order scoreboard.
module tb_pipe_add_sub;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             ci;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             co, ovf;

  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .ci(ci), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  logic [9:0] sbq[$];
  logic       s_ir, s_ov, s_co, s_ovf, s_acc;
  logic [7:0] s_sum;
  logic       h_vld = 1'b0;
  logic [9:0] h_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // returns {co, ovf, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [1:0] o, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
    int ux, uy, sx, sy, ru, rs;
    logic rco, rovf;
    logic [7:0] rsum;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    case (o)
      2'd0:    begin ru = ux + uy;       rs = sx + sy;       rco = (ru > 255); end
      2'd1:    begin ru = ux - uy;       rs = sx - sy;       rco = (ux >= uy); end
      2'd2:    begin ru = ux + 1;        rs = sx + 1;        rco = (ux == 255); end
      default: begin ru = ux + uy + int'(c); rs = sx + sy + int'(c); rco = (ru > 255); end
    endcase
    rovf = (rs > 127) || (rs < -128);
    rsum = ru[7:0];
    return {rco, rovf, rsum};
  endfunction

  // drive one cycle's inputs (called at a falling edge), sample, score, advance
  task automatic step(input logic v, input logic [1:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic cc, input logic ordy);
    logic [9:0] want;
    in_valid = v; op = o; a = aa; b = bb; ci = cc; out_ready = ordy;
    #1;
    s_ir = in_ready; s_ov = out_valid; s_sum = sum; s_co = co; s_ovf = ovf;
    s_acc = v && in_ready && rst_n;
    if (rst_n) begin
      if (h_vld) chk("hold", 32'({out_valid, co, ovf, sum}), 32'({1'b1, h_val}));
      if (!out_valid) chk("gate", 32'({co, ovf, sum}), 32'd0);
      if (out_valid && out_ready) begin
        chk("sb_avail", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          want = sbq.pop_front();
          chk("sb", 32'({co, ovf, sum}), 32'(want));
        end
      end
      if (s_acc) sbq.push_back(model(o, aa, bb, cc));
      h_vld = out_valid && !out_ready;
      h_val = {co, ovf, sum};
    end else begin
      sbq.delete();
      h_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic one(input string tag, input logic [1:0] o, input logic [7:0] aa,
                     input logic [7:0] bb, input logic cc, input logic [7:0] es,
                     input logic eco, input logic eovf);
    step(1'b1, o, aa, bb, cc, 1'b1);
    chk({tag, "_acc"}, 32'(s_acc), 32'd1);
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk({tag, "_lat1"}, 32'(s_ov), 32'd0);
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk({tag, "_vld"}, 32'(s_ov), 32'd1);
    chk({tag, "_sum"}, 32'(s_sum), 32'(es));
    chk({tag, "_co"},  32'(s_co),  32'(eco));
    chk({tag, "_ovf"}, 32'(s_ovf), 32'(eovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, stall, n_out;
    logic seen, ordy;
    logic [7:0] outs[$];

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("rst_ovld", 32'(s_ov), 32'd0);
    chk("rst_sum",  32'(s_sum), 32'd0);
    chk("rst_co",   32'(s_co), 32'd0);
    chk("rst_ovf",  32'(s_ovf), 32'd0);
    chk("rst_irdy", 32'(s_ir), 32'd1);

    one("add_wrap", 2'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
    one("sub_borrow", 2'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
    one("sub_ovf", 2'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    one("inc_ovf", 2'd2, 8'h7F, 8'h55, 1'b0, 8'h80, 1'b0, 1'b1);
    one("addc_ovf", 2'd3, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // stall: 4 back-to-back ADDs, out_ready low 3 cycles from first result
    k = 0; stall = 0; seen = 1'b0; n_out = 0;
    for (int c = 0; c < 20; c++) begin
      ordy = 1'b1;
      if (out_valid && !seen) begin seen = 1'b1; stall = 3; end
      if (stall > 0) ordy = 1'b0;
      step(k < 4, 2'd0, 8'(k + 1), 8'(k + 1), 1'b0, ordy);
      if (stall > 0) begin
        chk("stall_irdy", 32'(s_ir), 32'd0);
        chk("stall_sum", 32'(s_sum), 32'h02);
        stall--;
      end
      if (s_acc) k++;
      if (s_ov && ordy) begin outs.push_back(s_sum); n_out++; end
    end
    chk("stall_nin", 32'(k), 32'd4);
    chk("stall_nout", 32'(n_out), 32'd4);
    for (int i = 0; i < 4 && i < outs.size(); i++)
      chk("stall_order", 32'(outs[i]), 32'(2 * (i + 1)));

    // reset with operations in flight
    step(1'b1, 2'd0, 8'h11, 8'h22, 1'b0, 1'b1);
    step(1'b1, 2'd1, 8'h33, 8'h01, 1'b0, 1'b1);
    step(1'b1, 2'd2, 8'h44, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("mrst_ovld", 32'(s_ov), 32'd0);
    chk("mrst_sum", 32'(s_sum), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
      chk("mrst_quiet", 32'(s_ov), 32'd0);
    end
    one("post_rst", 2'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 9) < 7, 2'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 9) < 7);
    for (int i = 0; i < 10; i++)
      step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
